// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: opcode and add/sub unit FSM states.
package calc_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  typedef enum logic {S_IDLE, S_RUN} addsub_state_e;

endpackage

// File: rtl/chunk_adder_nbits.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also exposes
// the carry entering the top bit so the caller can compute signed overflow.
module chunk_adder_nbits #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/add_sub_serial_nbits.sv
// Digit-serial add/subtract unit: processes CHUNK bits per clock, start/done
// handshake, reports carry/borrow, signed overflow and zero.
module add_sub_serial_nbits
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             done_o
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("add_sub_serial_nbits: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
    end
  endgenerate

  addsub_state_e    state;
  op_e              op_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;

  logic [CHUNK-1:0] sum;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;

  chunk_adder_nbits #(.CHUNK(CHUNK)) u_chunk_adder (
    .a        (a_sh[CHUNK-1:0]),
    .b        (b_sh[CHUNK-1:0]),
    .cin      (carry),
    .sum      (sum),
    .cout     (c_out),
    .c_msb_in (c_msb)
  );

  // New sum bits enter at the MSB end; after N chunks the result is aligned.
  assign res_next = (res_sh >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      op_r    <= OP_ADD;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      ready_o <= 1'b1;
      s_o     <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
      zero_o  <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with op.
            op_r    <= op_e'(op_i);
            a_sh    <= a_i;
            b_sh    <= op_i ? ~b_i : b_i;
            carry   <= op_i;
            cnt     <= '0;
            ready_o <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          res_sh <= res_next;
          carry  <= c_out;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            s_o     <= res_next;
            cout_o  <= (op_r == OP_SUB) ? ~c_out : c_out;
            ovf_o   <= c_msb ^ c_out;
            zero_o  <= (res_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial_nbits.sv
// Scoreboard bench: directed vectors on a WIDTH=8/CHUNK=2 unit, plus a shared
// vector sweep across CHUNK=1,2,4,8 instances checked against an integer model.
module tb_add_sub_serial_nbits;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
    int         st_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Integer reference, independent of any carry-chain formulation.
  function automatic exp_t ref_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                                  input int st);
    exp_t e;
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = int'($signed(x));
    int   sy = int'($signed(y));
    int   r;
    int   sr;
    if (!o) begin
      r   = ux + uy;
      sr  = sx + sy;
      e.c = (r > 255);
    end else begin
      r   = ux - uy;
      sr  = sx - sy;
      e.c = (ux < uy);
    end
    e.v      = (sr > 127) || (sr < -128);
    e.s      = 8'(r);
    e.z      = (e.s == 8'h00);
    e.st_cyc = st;
    return e;
  endfunction

  // ---------------- main DUT (CHUNK=2) ----------------
  logic       start, op, ready, cout, ovf, zero, done;
  logic [7:0] a, b, s;
  exp_t       q_main[$];

  add_sub_serial_nbits #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .ready_o (ready),
    .s_o     (s),
    .cout_o  (cout),
    .ovf_o   (ovf),
    .zero_o  (zero),
    .done_o  (done)
  );

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (q_main.size() == 0) begin
        check("main_unexpected_done", 1, 0);
      end else begin
        e = q_main.pop_front();
        check("main_s", int'(s), int'(e.s));
        check("main_cout", int'(cout), int'(e.c));
        check("main_ovf", int'(ovf), int'(e.v));
        check("main_zero", int'(zero), int'(e.z));
        check("main_latency", cyc - e.st_cyc, 4);
      end
    end
  end

  // ---------------- sweep DUTs (CHUNK=1,2,4,8) ----------------
  logic       sw_start, sw_op;
  logic [7:0] sw_a, sw_b;
  logic [3:0] sw_ready, sw_done, sw_c, sw_v, sw_z;
  logic [7:0] sw_s[4];
  exp_t       q_sw[4][$];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned CH = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;

    add_sub_serial_nbits #(.WIDTH(8), .CHUNK(CH)) u_sw (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (sw_start),
      .op_i    (sw_op),
      .a_i     (sw_a),
      .b_i     (sw_b),
      .ready_o (sw_ready[g]),
      .s_o     (sw_s[g]),
      .cout_o  (sw_c[g]),
      .ovf_o   (sw_v[g]),
      .zero_o  (sw_z[g]),
      .done_o  (sw_done[g])
    );

    always @(negedge clk) begin
      if (!rst && sw_done[g]) begin
        exp_t e;
        if (q_sw[g].size() == 0) begin
          check($sformatf("sw%0d_unexpected_done", CH), 1, 0);
        end else begin
          e = q_sw[g].pop_front();
          check($sformatf("sw%0d_s", CH), int'(sw_s[g]), int'(e.s));
          check($sformatf("sw%0d_cout", CH), int'(sw_c[g]), int'(e.c));
          check($sformatf("sw%0d_ovf", CH), int'(sw_v[g]), int'(e.v));
          check($sformatf("sw%0d_zero", CH), int'(sw_z[g]), int'(e.z));
          check($sformatf("sw%0d_latency", CH), cyc - e.st_cyc, int'(8 / CH));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] es, input logic ec, input logic ev, input logic ez);
    exp_t e;
    int   k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("main_ready_timeout", 0, 1);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e     = '{s: es, c: ec, v: ev, z: ez, st_cyc: cyc + 1};
    q_main.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain_main();
    int k = 0;
    while (q_main.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("main_drain", q_main.size(), 0);
  endtask

  task automatic sw_issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    int k = 0;
    @(negedge clk);
    while (sw_ready != 4'hF && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sw_ready != 4'hF) check("sw_ready_timeout", int'(sw_ready), 15);
    sw_op    = o;
    sw_a     = x;
    sw_b     = y;
    sw_start = 1'b1;
    for (int i = 0; i < 4; i++) q_sw[i].push_back(ref_op(o, x, y, cyc + 1));
    @(posedge clk);
    #1 sw_start = 1'b0;
  endtask

  task automatic drain_sw();
    int k = 0;
    while ((q_sw[0].size() + q_sw[1].size() + q_sw[2].size() + q_sw[3].size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("sw_drain", q_sw[0].size() + q_sw[1].size() + q_sw[2].size() + q_sw[3].size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vals[6];
    rst      = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    sw_start = 1'b0;
    sw_op    = 1'b0;
    sw_a     = 8'h00;
    sw_b     = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_s", int'(s), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    // Basic add with ready held low for the four run cycles
    issue(1'b0, 8'h64, 8'h1B, 8'h7F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_ready", int'(ready), 0);
    end
    drain_main();

    issue(1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 8'h2A, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b1);
    drain_main();

    // Start while busy is ignored; start in the done cycle is accepted
    issue(1'b0, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ignored_start_ready", int'(ready), 0);
    op    = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    issue(1'b0, 8'h30, 8'h05, 8'h35, 1'b0, 1'b0, 1'b0);
    drain_main();

    // Reset in the middle of a run aborts it without a done pulse
    issue(1'b0, 8'h55, 8'h22, 8'h77, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q_main.delete();
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    check("abort_s", int'(s), 0);
    check("abort_zero", int'(zero), 1);
    check("abort_cout", int'(cout), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b0);
    drain_main();

    // Shared sweep: corner operands then pseudo-random ones, both ops
    vals = '{0, 1, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int o = 0; o < 2; o++)
          sw_issue(1'(o), 8'(vals[i]), 8'(vals[j]));
    for (int n = 0; n < 100; n++)
      sw_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain_sw();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
